serial_adder_ctrl: RTL and testbench

//  Bit-serial adder/subtractor controller. It time-shares one 1-bit full_adder cell across WIDTH-bit operands.

---
 rtl/serial_adder_ctrl_pkg.sv | 19 +
 rtl/serial_adder_ctrl_full_adder.sv | 16 +
 rtl/serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// the widest supported operand and the bit-counter sizing helper.
package adder_pkg;

    localparam int MAX_WIDTH = 32;

    // 2'd3 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit counter for a given operand width (never below 1 bit).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : adder_pkg

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, time-shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    // Plain combinational sum and carry.
    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller. Operands are accepted in IDLE,
// summed LSB-first one bit per clock through one full_adder cell in RUN, and
// the result with carry and signed overflow is held in DONE until taken.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH must be in 2..32");
    end

    state_t          state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            fa_sum;
    logic            fa_cout;

    full_adder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // Controller FSM: operand capture, one bit per clock, result hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
                        sh_a     <= a;
                        sh_b     <= op_sub ? ~b : b;
                        carry    <= op_sub ? 1'b1 : c_in;
                        cnt      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    if (cnt == LAST) begin
                        // MSB step: carry register still holds the carry into the MSB.
                        ovf       <= carry ^ fa_cout;
                        c_out     <= fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present one operand pair in IDLE, return cycles until out_valid and the result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, output int lat, output logic [W-1:0] rs,
                          output logic rc, output logic ro);
        a = ta; b = tb_; c_in = tc; op_sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = c_out; ro = ovf;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, sum, c_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b o=%b required rdy=1 vld=0 sum=00 c=0 o=0",
                     in_ready, out_valid, sum, c_out, ovf);
        end
    endtask

    // Directed vectors: {a, b, c_in, op_sub, sum, c_out, ovf}
    task automatic test_vectors();
        logic [W-1:0] va [9];
        logic [W-1:0] vb [9];
        logic         vc [9];
        logic         vs [9];
        logic [W-1:0] es [9];
        logic         ec [9];
        logic         eo [9];
        int lat;
        logic [W-1:0] rs;
        logic rc, ro;
        va = '{8'h5A, 8'hFF, 8'h00, 8'h10, 8'h01, 8'h80, 8'h37, 8'h7F, 8'hC3};
        vb = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h02, 8'h01, 8'h37, 8'h01, 8'h3C};
        vc = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        vs = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        es = '{8'h96, 8'h00, 8'h01, 8'h0F, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h00};
        ec = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        eo = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], lat, rs, rc, ro);
            n_cmp++;
            if (lat !== W) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d required %0d", i, lat, W);
            end
            n_cmp++;
            if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
                n_bad++;
                $display("FAIL vector[%0d] %h%s%h: sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                         i, va[i], vs[i] ? "-" : "+", vb[i], rs, rc, ro, es[i], ec[i], eo[i]);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] rs;
        logic rc, ro;
        run_op(8'h12, 8'h34, 1'b1, 1'b0, lat, rs, rc, ro);
        // A second pair is offered while the result waits; it must be ignored.
        a = 8'hAA; b = 8'h55; c_in = 1'b0; op_sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, sum, c_out, ovf} !== {1'b1, 1'b0, 8'h47, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b sum=%h c=%b o=%b required vld=1 rdy=0 sum=47 c=0 o=0",
                         k, out_valid, in_ready, sum, c_out, ovf);
            end
        end
        in_valid = 1'b0;
        release_result();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL no_queue: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_rst_mid_run();
        int lat;
        logic seen;
        logic [W-1:0] rs;
        logic rc, ro;
        // Leave nonzero c_out/ovf behind so the reset clearing them is visible.
        run_op(8'h80, 8'h80, 1'b0, 1'b0, lat, rs, rc, ro);
        release_result();
        a = 8'h11; b = 8'h22; c_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, sum, c_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_run: rdy=%b vld=%b sum=%h c=%b o=%b required rdy=1 vld=0 sum=00 c=0 o=0",
                     in_ready, out_valid, sum, c_out, ovf);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_pulse: out_valid seen=%b required 0", seen);
        end
        run_op(8'hE0, 8'h30, 1'b0, 1'b1, lat, rs, rc, ro);
        n_cmp++;
        if ({lat == W, rs, rc, ro} !== {1'b1, 8'hB0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL after_rst: lat=%0d sum=%h c=%b o=%b required lat=%0d sum=b0 c=1 o=0",
                     lat, rs, rc, ro, W);
        end
        release_result();
    endtask

    // Accept edge, WIDTH RUN edges, one DONE edge, then an IDLE cycle before the next accept.
    task automatic test_back_to_back();
        logic [W-1:0] pa, pb, eb, es;
        logic pc, ps, ec, eo;
        logic [W:0] full;
        int acc, prev, t;
        out_ready = 1'b1;
        pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom); ps = 1'($urandom);
        a = pa; b = pb; c_in = pc; op_sub = ps; in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            t = 0;
            while (!in_ready && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            eb   = ps ? ~pb : pb;
            full = {1'b0, pa} + {1'b0, eb} + {{W{1'b0}}, (ps ? 1'b1 : pc)};
            es = full[W-1:0];
            ec = full[W];
            eo = (pa[W-1] == eb[W-1]) && (es[W-1] != pa[W-1]);
            if (i > 0) begin
                n_cmp++;
                if (acc - prev !== W + 2) begin
                    n_bad++;
                    $display("FAIL b2b_interval[%0d]: got %0d required %0d", i, acc - prev, W + 2);
                end
            end
            prev = acc;
            pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom); ps = 1'($urandom);
            a = pa; b = pb; c_in = pc; op_sub = ps;
            if (i == 255) in_valid = 1'b0;
            t = 0;
            while (!out_valid && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            n_cmp++;
            if ({out_valid, sum, c_out, ovf} !== {1'b1, es, ec, eo}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: vld=%b sum=%h c=%b o=%b required vld=1 sum=%h c=%b o=%b",
                         i, out_valid, sum, c_out, ovf, es, ec, eo);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_rst_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
